// File: rtl/seq_alu_pkg.sv
// Shared types for the registered multi-cycle accumulator ALU (seq_alu).
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_AND = 4'd1,
    OP_LDA = 4'd2,
    OP_CMA = 4'd3,
    OP_CIR = 4'd4,
    OP_CIL = 4'd5,
    OP_TRA = 4'd6,
    OP_SUB = 4'd7,
    OP_INC = 4'd8,
    OP_OR  = 4'd9,
    OP_XOR = 4'd10,
    OP_MUL = 4'd11,
    OP_DIV = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Codes 0..OP_LAST_SINGLE complete in one cycle; above that is iterative or invalid.
  localparam logic [3:0] OP_LAST_SINGLE = 4'd10;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for seq_alu: shift-add multiply or restoring divide, one
// step per cycle, W steps per operation. hi holds product-high / remainder, lo holds product-low / quotient.
module seq_alu_iter #(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         div_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         last_step_o,
  output logic [W-1:0] hi_nxt_o,
  output logic [W-1:0] lo_nxt_o
);

  logic [W-1:0]  hi_q, lo_q, b_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    sum, rem_sh;

  always_comb begin
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {hi_q, lo_q[W-1]};
    hi_nxt_o = sum[W:1];
    lo_nxt_o = {sum[0], lo_q[W-1:1]};
    if (div_i) begin
      if (rem_sh >= {1'b0, b_q}) begin
        hi_nxt_o = W'(rem_sh - {1'b0, b_q});
        lo_nxt_o = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_nxt_o = rem_sh[W-1:0];
        lo_nxt_o = {lo_q[W-2:0], 1'b0};
      end
    end
  end

  assign last_step_o = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      cnt_q <= CW'(W);
    end else if (step_i) begin
      hi_q  <= hi_nxt_o;
      lo_q  <= lo_nxt_o;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered multi-cycle accumulator ALU with start/busy/done handshake.
// Define ALU_DIV_EN to turn op 12 into an iterative unsigned divide.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops finish at the accepting edge
// MUL   | iterative multiply/divide in progress (busy)
// DONE  | results just updated, done pulse, start ignored
module seq_alu #(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] AC,
  input  logic [W-1:0] DR,
  input  logic         E_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic         E_out,
  output logic         CO,
  output logic         OVF,
  output logic         Z,
  output logic         N
);
  import seq_alu_pkg::*;

  state_e       state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic         eout_q, eout_d, co_q, co_d, ovf_q, ovf_d, ein_q;
  logic         upd, load, step, last_step, is_iter;
  logic [W-1:0] hi_nxt, lo_nxt;
  logic [W:0]   sum;
`ifdef ALU_DIV_EN
  logic         div_q, dr_zero_q;
`endif

  seq_alu_iter #(.W(W), .CW(CW)) u_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .step_i      (step),
`ifdef ALU_DIV_EN
    .div_i       (div_q),
`else
    .div_i       (1'b0),
`endif
    .a_i         (AC),
    .b_i         (DR),
    .last_step_o (last_step),
    .hi_nxt_o    (hi_nxt),
    .lo_nxt_o    (lo_nxt)
  );

`ifdef ALU_DIV_EN
  assign is_iter = (op == OP_MUL) || (op == OP_DIV);
`else
  assign is_iter = (op == OP_MUL);
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    upd     = 1'b0;
    sum     = '0;
    out_d   = '0;
    eout_d  = ein_q;
    co_d    = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_iter) begin
            load    = 1'b1;
            state_d = MUL;
          end else begin
            upd     = 1'b1;
            state_d = DONE;
            eout_d  = E_in;
            if (op <= OP_LAST_SINGLE) begin
              case (op)
                OP_ADD: begin
                  sum    = {1'b0, AC} + {1'b0, DR};
                  out_d  = sum[W-1:0];
                  co_d   = sum[W];
                  ovf_d  = (AC[W-1] == DR[W-1]) && (sum[W-1] != AC[W-1]);
                  eout_d = sum[W];
                end
                OP_AND: out_d = AC & DR;
                OP_LDA: out_d = DR;
                OP_CMA: out_d = ~AC;
                OP_CIR: begin
                  out_d  = {E_in, AC[W-1:1]};
                  eout_d = AC[0];
                end
                OP_CIL: begin
                  out_d  = {AC[W-2:0], E_in};
                  eout_d = AC[W-1];
                end
                OP_TRA: out_d = AC;
                OP_SUB: begin
                  // CO=1 means no borrow
                  sum    = {1'b0, AC} + {1'b0, ~DR} + (W+1)'(1);
                  out_d  = sum[W-1:0];
                  co_d   = sum[W];
                  ovf_d  = (AC[W-1] != DR[W-1]) && (sum[W-1] != AC[W-1]);
                  eout_d = sum[W];
                end
                OP_INC: begin
                  sum    = {1'b0, AC} + (W+1)'(1);
                  out_d  = sum[W-1:0];
                  co_d   = sum[W];
                  ovf_d  = (AC == {1'b0, {(W-1){1'b1}}});
                  eout_d = sum[W];
                end
                OP_OR:   out_d = AC | DR;
                OP_XOR:  out_d = AC ^ DR;
                default: out_d = '0;
              endcase
            end
          end
        end
      end
      MUL: begin
        step = 1'b1;
        if (last_step) begin
          upd     = 1'b1;
          state_d = DONE;
          out_d   = lo_nxt;
          co_d    = (hi_nxt != '0);
          ovf_d   = (hi_nxt != '0);
`ifdef ALU_DIV_EN
          if (div_q) begin
            out_d = dr_zero_q ? '1 : lo_nxt;
            ovf_d = dr_zero_q;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      eout_q    <= 1'b0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
      ein_q     <= 1'b0;
`ifdef ALU_DIV_EN
      div_q     <= 1'b0;
      dr_zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        ein_q     <= E_in;
`ifdef ALU_DIV_EN
        div_q     <= (op == OP_DIV);
        dr_zero_q <= (DR == '0);
`endif
      end
      if (upd) begin
        out_q  <= out_d;
        eout_q <= eout_d;
        co_q   <= co_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign busy  = (state_q == MUL);
  assign done  = (state_q == DONE);
  assign out   = out_q;
  assign E_out = eout_q;
  assign CO    = co_q;
  assign OVF   = ovf_q;
  assign Z     = (out_q == '0);
  assign N     = out_q[W-1];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results, monitor checks on done.
module tb_seq_alu;
  localparam int W     = 16;
  localparam int MASK  = (1 << W) - 1;
  localparam int MAXS  = (1 << (W-1)) - 1;
  localparam int MINS  = -(1 << (W-1));

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, E_in = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] AC = '0, DR = '0;
  logic         busy, done, E_out, CO, OVF, Z, N;
  logic [W-1:0] out;

  seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .AC(AC), .DR(DR), .E_in(E_in),
    .busy(busy), .done(done), .out(out), .E_out(E_out), .CO(CO), .OVF(OVF), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] o;
    logic         e, co, ovf;
    int           lat, bcyc, t0;
  } exp_t;

  exp_t q[$];
  exp_t hold;
  int   checks = 0, passes = 0;
  int   bcnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic int sgn(int v);
    return (v > MAXS) ? v - (1 << W) : v;
  endfunction

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(int o, int a, int d, logic e);
    exp_t   r;
    int     s;
    longint p;
    r.o = '0; r.e = e; r.co = 1'b0; r.ovf = 1'b0; r.lat = 1; r.bcyc = 0; r.t0 = 0;
    case (o)
      0:  begin s = a + d; r.o = W'(s); r.co = (s > MASK);
            r.ovf = (sgn(a) + sgn(d) > MAXS) || (sgn(a) + sgn(d) < MINS); r.e = r.co; end
      1:  r.o = W'(a & d);
      2:  r.o = W'(d);
      3:  r.o = W'(MASK - a);
      4:  begin r.o = W'((int'(e) << (W-1)) + (a >> 1)); r.e = a[0]; end
      5:  begin r.o = W'(((a * 2) & MASK) + int'(e)); r.e = a[W-1]; end
      6:  r.o = W'(a);
      7:  begin r.o = W'(a - d); r.co = (a >= d);
            r.ovf = (sgn(a) - sgn(d) > MAXS) || (sgn(a) - sgn(d) < MINS); r.e = r.co; end
      8:  begin r.o = W'(a + 1); r.co = (a == MASK); r.ovf = (a == MAXS); r.e = r.co; end
      9:  r.o = W'(a | d);
      10: r.o = W'(a ^ d);
      11: begin p = longint'(a) * longint'(d); r.o = W'(p); r.co = (p > MASK); r.ovf = r.co;
            r.lat = W + 1; r.bcyc = W; end
`ifdef ALU_DIV_EN
      12: begin r.lat = W + 1; r.bcyc = W;
            if (d == 0) begin r.o = W'(MASK); r.ovf = 1'b1; r.co = (a != 0); end
            else begin r.o = W'(a / d); r.co = ((a % d) != 0); end
          end
`endif
      default: r.o = '0;
    endcase
    return r;
  endfunction

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold.o = '0; hold.e = 1'b0; hold.co = 1'b0; hold.ovf = 1'b0;
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (done) begin
          if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
          end else begin
            x = q.pop_front();
            chk("out", 32'(out), 32'(x.o));
            chk("E_out", 32'(E_out), 32'(x.e));
            chk("CO", 32'(CO), 32'(x.co));
            chk("OVF", 32'(OVF), 32'(x.ovf));
            chk("Z", 32'(Z), 32'(x.o == '0));
            chk("N", 32'(N), 32'(x.o[W-1]));
            chk("latency", 32'(cyc - x.t0), 32'(x.lat));
            chk("busy_cycles", 32'(bcnt), 32'(x.bcyc));
            chk("busy_in_done", 32'(busy), 32'd0);
            hold = x;
          end
          bcnt = 0;
        end else begin
          chk("hold", 32'({out, E_out, CO, OVF, Z, N}),
              32'({hold.o, hold.e, hold.co, hold.ovf, hold.o == '0, hold.o[W-1]}));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy || done) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        checks++;
        $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle within 100 cycles", busy, done);
        return;
      end
    end
  endtask

  task automatic issue(int o, int a, int d, logic e);
    exp_t x;
    wait_idle();
    op = 4'(o); AC = W'(a); DR = W'(d); E_in = e; start = 1'b1;
    x = model(o, a, d, e);
    x.t0 = cyc;
    q.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return MAXS;
      2: return MAXS + 1;
      3: return MASK;
      4: return 1;
      default: return int'($urandom_range(0, MASK));
    endcase
  endfunction

  initial begin : driver
    int n;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flags", 32'({E_out, CO, OVF, Z, N}), 32'b00010);
    chk("rst_hs", 32'({busy, done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 'h7FFF, 'h0001, 1'b0);
    issue(7, 'h0003, 'h0005, 1'b1);
    issue(7, 'h0005, 'h0005, 1'b0);
    issue(5, 'h8001, 'h1234, 1'b0);
    issue(4, 'h0001, 'h0000, 1'b1);
    issue(8, 'h7FFF, 'h0000, 1'b0);
    issue(8, 'hFFFF, 'h0000, 1'b1);
    issue(11, 'h0100, 'h0100, 1'b1);
    repeat (4) @(negedge clk);
    op = 4'd2; DR = 'h5555; start = 1'b1;       // ignored while busy
    @(negedge clk);
    start = 1'b0;
    issue(11, 'h00FF, 'h0101, 1'b0);
    issue(12, 100, 7, 1'b1);
    issue(12, 'h1234, 0, 1'b0);
    issue(15, 'hFFFF, 'hFFFF, 1'b1);
    issue(6, 'hA5A5, 'h0000, 1'b0);
    op = 4'd3; AC = 'h0F0F; start = 1'b1;       // arrives in DONE, must be dropped
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 300; i++)
      issue(int'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)));

    // reset in the middle of a multiply
    issue(11, pick(), pick(), 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hs", 32'({busy, done}), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_flags", 32'({E_out, CO, OVF, Z, N}), 32'b00010);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 6) @(negedge clk);
    issue(0, 'h0001, 'h0002, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
